// File: rtl/vending_fsm_param_if.sv
// vending_fsm_param_if
// Purpose: bundles the coin-acceptor pulses and the brewer/refund outputs
//          of the parametrised coffee vending controller into one bus.
// Signals:
//   bani50, bani100, cancel  one-cycle request pulses from the coin acceptor
//   cafea                    high while brewing
//   busy                     high while dispensing or refunding
//   credit                   current credit register, in bani
//   rest_valid, rest         one-cycle refund strobe and refund amount
//   coin_reject              one-cycle pulse, previous cycle's coin(s) refused
// Modports:
//   master  coin acceptor / supervisor side (drives the request pulses)
//   slave   controller side (drives the actuator outputs)
interface vending_fsm_param_if #(
  parameter int CREDIT_W = 9
);

  logic                bani50;
  logic                bani100;
  logic                cancel;
  logic                cafea;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic                rest_valid;
  logic [CREDIT_W-1:0] rest;
  logic                coin_reject;

  modport master (
    output bani50,
    output bani100,
    output cancel,
    input  cafea,
    input  busy,
    input  credit,
    input  rest_valid,
    input  rest,
    input  coin_reject
  );

  modport slave (
    input  bani50,
    input  bani100,
    input  cancel,
    output cafea,
    output busy,
    output credit,
    output rest_valid,
    output rest,
    output coin_reject
  );

endinterface

// File: rtl/vending_fsm_param.sv
// vending_fsm_param
// Purpose: Moore-style coffee vending controller. Credit is held in a binary
//          counter; price, credit ceiling, brew duration and the handling of
//          excess credit (carry over or refund) are parameters.
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous, active-low reset (0 = reset); clears credit
//   bus     vending_fsm_param_if slave modport:
//             in : bani50, bani100, cancel
//             out: cafea, busy, credit, rest_valid, rest, coin_reject
// Parameters:
//   CREDIT_W         width of credit/rest, must hold MAX_CREDIT
//   PRICE            coffee price in bani, must be > 0
//   MAX_CREDIT       coins that would push credit above this are rejected
//   DISPENSE_CYCLES  cycles cafea stays high per coffee, must be >= 1
//   CARRY            1 = excess credit kept, 0 = excess refunded after brewing
module vending_fsm_param #(
  parameter int CREDIT_W        = 9,
  parameter int PRICE           = 200,
  parameter int MAX_CREDIT      = 300,
  parameter int DISPENSE_CYCLES = 3,
  parameter int CARRY           = 1
) (
  input logic                  clock,
  input logic                  reset,
  vending_fsm_param_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  localparam int CNT_W = (DISPENSE_CYCLES < 2) ? 1 : $clog2(DISPENSE_CYCLES + 1);

  // All credit arithmetic uses one extra bit so the ceiling check never wraps.
  localparam logic [CREDIT_W:0]  PRICE_X  = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W:0]  MAX_X    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DISPENSE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    cnt;
  logic                cafea_q;
  logic                busy_q;
  logic                rest_valid_q;
  logic [CREDIT_W-1:0] rest_q;
  logic                coin_reject_q;

  logic                coin;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   credit_x;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   sum_minus_price;
  logic [CREDIT_W:0]   credit_minus_price;
  logic                over_max;
  logic                reach_price;
  logic                credit_ge_price;
  logic                credit_nz;

  // Both coins in the same cycle are accepted (or refused) as one 150 sum.
  always_comb begin
    coin_val = '0;
    case ({bus.bani100, bus.bani50})
      2'b01:   coin_val = (CREDIT_W + 1)'(50);
      2'b10:   coin_val = (CREDIT_W + 1)'(100);
      2'b11:   coin_val = (CREDIT_W + 1)'(150);
      default: coin_val = '0;
    endcase
  end

  assign coin               = bus.bani50 | bus.bani100;
  assign credit_x           = {1'b0, credit_q};
  assign sum                = credit_x + coin_val;
  assign sum_minus_price    = sum - PRICE_X;
  assign credit_minus_price = credit_x - PRICE_X;
  assign over_max           = sum > MAX_X;
  assign reach_price        = sum >= PRICE_X;
  assign credit_ge_price    = credit_x >= PRICE_X;
  assign credit_nz          = credit_q != '0;

  // Single-process FSM. The Moore outputs are registered alongside the state
  // they belong to, so each branch sets the outputs of the state it enters;
  // the defaults at the top cover IDLE/COLLECT (everything low).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      credit_q      <= '0;
      cnt           <= '0;
      cafea_q       <= 1'b0;
      busy_q        <= 1'b0;
      rest_valid_q  <= 1'b0;
      rest_q        <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      cafea_q       <= 1'b0;
      busy_q        <= 1'b0;
      rest_valid_q  <= 1'b0;
      rest_q        <= '0;
      coin_reject_q <= 1'b0;

      case (state)
        IDLE, COLLECT: begin
          if (bus.cancel && credit_nz) begin
            // Cancel wins over a coin arriving in the same cycle.
            state         <= REFUND;
            busy_q        <= 1'b1;
            rest_valid_q  <= 1'b1;
            rest_q        <= credit_q;
            coin_reject_q <= coin;
          end else if (coin && over_max) begin
            coin_reject_q <= 1'b1;
          end else if (coin && reach_price) begin
            credit_q <= sum_minus_price[CREDIT_W-1:0];
            cnt      <= CNT_LOAD;
            state    <= DISPENSE;
            cafea_q  <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            credit_q <= sum[CREDIT_W-1:0];
            state    <= (sum == '0) ? IDLE : COLLECT;
          end
        end

        DISPENSE: begin
          coin_reject_q <= coin;
          if (cnt > CNT_ONE) begin
            cnt     <= cnt - CNT_ONE;
            cafea_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (credit_ge_price) begin
            // Enough credit left for another cup: brew again without a gap.
            credit_q <= credit_minus_price[CREDIT_W-1:0];
            cnt      <= CNT_LOAD;
            cafea_q  <= 1'b1;
            busy_q   <= 1'b1;
          end else if ((CARRY == 0) && credit_nz) begin
            cnt          <= '0;
            state        <= REFUND;
            busy_q       <= 1'b1;
            rest_valid_q <= 1'b1;
            rest_q       <= credit_q;
          end else begin
            cnt   <= '0;
            state <= credit_nz ? COLLECT : IDLE;
          end
        end

        REFUND: begin
          coin_reject_q <= coin;
          credit_q      <= '0;
          state         <= IDLE;
        end

        default: begin
          state    <= IDLE;
          credit_q <= '0;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.cafea       = cafea_q;
  assign bus.busy        = busy_q;
  assign bus.credit      = credit_q;
  assign bus.rest_valid  = rest_valid_q;
  assign bus.rest        = rest_q;
  assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// tb_vending_fsm_param
// Purpose: self-checking bench for vending_fsm_param. Four instances cover
//          the default build, excess refund (CARRY=0), a price above the
//          credit ceiling, and a cheap single-cycle brew for back-to-back cups.
//          Expected outputs are queued when a stimulus cycle is driven and
//          compared after the clock edge that consumes it.
module tb_vending_fsm_param;

  localparam int CW = 9;

  logic clock;
  logic rst_n;

  vending_fsm_param_if #(.CREDIT_W(CW)) if_def ();
  vending_fsm_param_if #(.CREDIT_W(CW)) if_nc ();
  vending_fsm_param_if #(.CREDIT_W(CW)) if_hp ();
  vending_fsm_param_if #(.CREDIT_W(CW)) if_bb ();

  vending_fsm_param #(.CREDIT_W(CW)) u_def (
    .clock (clock),
    .reset (rst_n),
    .bus   (if_def)
  );

  vending_fsm_param #(.CREDIT_W(CW), .CARRY(0)) u_nc (
    .clock (clock),
    .reset (rst_n),
    .bus   (if_nc)
  );

  vending_fsm_param #(.CREDIT_W(CW), .PRICE(400), .MAX_CREDIT(300)) u_hp (
    .clock (clock),
    .reset (rst_n),
    .bus   (if_hp)
  );

  vending_fsm_param #(.CREDIT_W(CW), .PRICE(50), .DISPENSE_CYCLES(1)) u_bb (
    .clock (clock),
    .reset (rst_n),
    .bus   (if_bb)
  );

  localparam int DEF = 0;
  localparam int NC  = 1;
  localparam int HP  = 2;
  localparam int BB  = 3;

  typedef struct {
    string       tag;
    int          dut;
    logic [21:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packs one cycle's outputs: {cafea, busy, rest_valid, coin_reject, credit, rest}.
  function automatic logic [21:0] pk(input bit caf, input bit bsy, input bit rv,
                                     input bit rej, input int cr, input int rs);
    return {caf, bsy, rv, rej, CW'(cr), CW'(rs)};
  endfunction

  function automatic logic [21:0] obs(input int dut);
    case (dut)
      NC:      return {if_nc.cafea, if_nc.busy, if_nc.rest_valid, if_nc.coin_reject, if_nc.credit, if_nc.rest};
      HP:      return {if_hp.cafea, if_hp.busy, if_hp.rest_valid, if_hp.coin_reject, if_hp.credit, if_hp.rest};
      BB:      return {if_bb.cafea, if_bb.busy, if_bb.rest_valid, if_bb.coin_reject, if_bb.credit, if_bb.rest};
      default: return {if_def.cafea, if_def.busy, if_def.rest_valid, if_def.coin_reject, if_def.credit, if_def.rest};
    endcase
  endfunction

  // Drives the request pulses of one instance and holds all others idle.
  task automatic drive(input int dut, input bit b50, input bit b100, input bit cnl);
    if_def.bani50  = b50  && (dut == DEF);
    if_def.bani100 = b100 && (dut == DEF);
    if_def.cancel  = cnl  && (dut == DEF);
    if_nc.bani50   = b50  && (dut == NC);
    if_nc.bani100  = b100 && (dut == NC);
    if_nc.cancel   = cnl  && (dut == NC);
    if_hp.bani50   = b50  && (dut == HP);
    if_hp.bani100  = b100 && (dut == HP);
    if_hp.cancel   = cnl  && (dut == HP);
    if_bb.bani50   = b50  && (dut == BB);
    if_bb.bani100  = b100 && (dut == BB);
    if_bb.cancel   = cnl  && (dut == BB);
  endtask

  task automatic checkOutput(input string tag, input logic [21:0] got, input logic [21:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got cafea=%0b busy=%0b rest_valid=%0b coin_reject=%0b credit=%0d rest=%0d; expected cafea=%0b busy=%0b rest_valid=%0b coin_reject=%0b credit=%0d rest=%0d",
               tag, got[21], got[20], got[19], got[18], got[17:9], got[8:0],
               expv[21], expv[20], expv[19], expv[18], expv[17:9], expv[8:0]);
    end
  endtask

  // One clock of stimulus: queue what the DUT must show after the edge,
  // let the edge sample the pulses, then drop them and score the result.
  task automatic applyStimulus(input string tag, input int dut, input bit b50, input bit b100,
                               input bit cnl, input logic [21:0] expv);
    exp_t e;
    drive(dut, b50, b100, cnl);
    e.tag = tag;
    e.dut = dut;
    e.val = expv;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    drive(DEF, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checkOutput(e.tag, obs(e.dut), e.val);
  endtask

  initial begin
    drive(DEF, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_def", obs(DEF), pk(0, 0, 0, 0, 0, 0));
    checkOutput("rst_nc",  obs(NC),  pk(0, 0, 0, 0, 0, 0));
    checkOutput("rst_hp",  obs(HP),  pk(0, 0, 0, 0, 0, 0));
    checkOutput("rst_bb",  obs(BB),  pk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    $display("[TB] single coins up to the price");
    applyStimulus("t1_b50a",  DEF, 1, 0, 0, pk(0, 0, 0, 0, 50, 0));
    applyStimulus("t1_b50b",  DEF, 1, 0, 0, pk(0, 0, 0, 0, 100, 0));
    applyStimulus("t1_b100",  DEF, 0, 1, 0, pk(1, 1, 0, 0, 0, 0));
    applyStimulus("t1_disp2", DEF, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    applyStimulus("t1_disp3", DEF, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    applyStimulus("t1_idle",  DEF, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] double coin and carried excess");
    applyStimulus("t2_b150",  DEF, 1, 1, 0, pk(0, 0, 0, 0, 150, 0));
    applyStimulus("t2_b100",  DEF, 0, 1, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("t2_disp2", DEF, 0, 0, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("t2_disp3", DEF, 0, 0, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("t2_carry", DEF, 0, 0, 0, pk(0, 0, 0, 0, 50, 0));
    applyStimulus("t2_cancel", DEF, 0, 0, 1, pk(0, 1, 1, 0, 50, 50));
    applyStimulus("t2_clear", DEF, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] refunded excess");
    applyStimulus("t2n_b150",  NC, 1, 1, 0, pk(0, 0, 0, 0, 150, 0));
    applyStimulus("t2n_b100",  NC, 0, 1, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("t2n_disp2", NC, 0, 0, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("t2n_disp3", NC, 0, 0, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("t2n_rest",  NC, 0, 0, 0, pk(0, 1, 1, 0, 50, 50));
    applyStimulus("t2n_idle",  NC, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] cancel beats a coin");
    applyStimulus("t3_b100",   DEF, 0, 1, 0, pk(0, 0, 0, 0, 100, 0));
    applyStimulus("t3_b50",    DEF, 1, 0, 0, pk(0, 0, 0, 0, 150, 0));
    applyStimulus("t3_cancel", DEF, 0, 1, 1, pk(0, 1, 1, 1, 150, 150));
    applyStimulus("t3_idle",   DEF, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] credit ceiling");
    applyStimulus("t4_b100a",  HP, 0, 1, 0, pk(0, 0, 0, 0, 100, 0));
    applyStimulus("t4_b100b",  HP, 0, 1, 0, pk(0, 0, 0, 0, 200, 0));
    applyStimulus("t4_over",   HP, 1, 1, 0, pk(0, 0, 0, 1, 200, 0));
    applyStimulus("t4_hold",   HP, 0, 0, 0, pk(0, 0, 0, 0, 200, 0));
    applyStimulus("t4_exact",  HP, 0, 1, 0, pk(0, 0, 0, 0, 300, 0));
    applyStimulus("t4_full",   HP, 1, 0, 0, pk(0, 0, 0, 1, 300, 0));
    applyStimulus("t4_cancel", HP, 0, 0, 1, pk(0, 1, 1, 0, 300, 300));
    applyStimulus("t4_idle",   HP, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] coin during dispense");
    applyStimulus("t5_b100a",  DEF, 0, 1, 0, pk(0, 0, 0, 0, 100, 0));
    applyStimulus("t5_b100b",  DEF, 0, 1, 0, pk(1, 1, 0, 0, 0, 0));
    applyStimulus("t5_disp2",  DEF, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    applyStimulus("t5_reject", DEF, 0, 1, 1, pk(1, 1, 0, 1, 0, 0));
    applyStimulus("t5_idle",   DEF, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] cancel with no credit");
    applyStimulus("tz_cancel0", DEF, 1, 0, 1, pk(0, 0, 0, 0, 50, 0));
    applyStimulus("tz_cancel",  DEF, 0, 0, 1, pk(0, 1, 1, 0, 50, 50));
    applyStimulus("tz_idle",    DEF, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] back-to-back cups");
    applyStimulus("tb_b150",  BB, 1, 1, 0, pk(1, 1, 0, 0, 100, 0));
    applyStimulus("tb_cup2",  BB, 0, 0, 0, pk(1, 1, 0, 0, 50, 0));
    applyStimulus("tb_cup3",  BB, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    applyStimulus("tb_idle",  BB, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));

    $display("[TB] asynchronous reset mid-dispense");
    applyStimulus("t6_b100",  DEF, 0, 1, 0, pk(0, 0, 0, 0, 100, 0));
    applyStimulus("t6_b150",  DEF, 1, 1, 0, pk(1, 1, 0, 0, 50, 0));
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async", obs(DEF), pk(0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    checkOutput("t6_held", obs(DEF), pk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    applyStimulus("t6_after", DEF, 0, 1, 0, pk(0, 0, 0, 0, 100, 0));
    applyStimulus("t6_stay",  DEF, 0, 0, 0, pk(0, 0, 0, 0, 100, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
